// File: rtl/decode_stage.sv
// decode_stage: registered instruction decoder with valid/ready handshake and a
// destination-register scoreboard that stalls on RAW/WAW hazards until writeback.
module decode_stage #(
  parameter int OPCODE_W = 5,
  parameter int REG_W    = 4,
  parameter int IMM_W    = 16,
  parameter int DATA_W   = 32,
  localparam int INSTR_W = OPCODE_W + 3*REG_W + IMM_W,
  localparam int NREG    = 1 << REG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [INSTR_W-1:0]  instruction,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OPCODE_W-1:0] opcode,
  output logic [REG_W-1:0]    reg_dest,
  output logic [REG_W-1:0]    reg_source_1,
  output logic [REG_W-1:0]    reg_source_2,
  output logic [DATA_W-1:0]   immediate,
  output logic                writes_dest,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_reg,
  output logic [NREG-1:0]     busy_mask,
  output logic                hazard_stall
);
  logic [OPCODE_W-1:0] in_op;
  logic [REG_W-1:0]    in_dst, in_s1, in_s2;
  logic [DATA_W-1:0]   in_imm;
  logic                in_wd;
  logic [NREG-1:0]     wb_clr, busy_eff, use_mask, set_mask, kill_mask;
  logic                hazard, space_ok, accept, handoff;
  logic                out_valid_d, out_valid_q, writes_dest_d, writes_dest_q;
  logic [OPCODE_W-1:0] opcode_d, opcode_q;
  logic [REG_W-1:0]    dest_d, dest_q, src1_d, src1_q, src2_d, src2_q;
  logic [DATA_W-1:0]   imm_d, imm_q;
  logic [NREG-1:0]     busy_d, busy_q;

  assign in_op  = instruction[INSTR_W-1 -: OPCODE_W];
  assign in_dst = instruction[IMM_W+3*REG_W-1 -: REG_W];
  assign in_s1  = instruction[IMM_W+2*REG_W-1 -: REG_W];
  assign in_s2  = instruction[IMM_W+REG_W-1 -: REG_W];
  assign in_imm = DATA_W'($signed(instruction[IMM_W-1:0]));
  assign in_wd  = (in_op != '0) && (in_dst != '0);

  always_comb begin
    wb_clr    = wb_valid ? (NREG'(1) << wb_reg) : '0;
    busy_eff  = busy_q & ~wb_clr;
    // register 0 never participates in hazard detection
    use_mask  = ((NREG'(1) << in_dst) | (NREG'(1) << in_s1) | (NREG'(1) << in_s2)) & ~NREG'(1);
    hazard    = in_valid && |(busy_eff & use_mask);
    space_ok  = !out_valid_q || out_ready;
    in_ready  = !flush && space_ok && !hazard;
    hazard_stall = in_valid && !flush && space_ok && hazard;
    accept    = in_valid && in_ready;
    handoff   = out_valid_q && out_ready;
    set_mask  = (accept && in_wd) ? (NREG'(1) << in_dst) : '0;
    // a flushed instruction that never reached execute releases its destination
    kill_mask = (flush && out_valid_q && !out_ready && writes_dest_q) ? (NREG'(1) << dest_q) : '0;
    busy_d    = (busy_q & ~wb_clr & ~kill_mask) | set_mask;
    out_valid_d   = accept ? 1'b1 : (flush || handoff) ? 1'b0 : out_valid_q;
    opcode_d      = accept ? in_op  : opcode_q;
    dest_d        = accept ? in_dst : dest_q;
    src1_d        = accept ? in_s1  : src1_q;
    src2_d        = accept ? in_s2  : src2_q;
    imm_d         = accept ? in_imm : imm_q;
    writes_dest_d = accept ? in_wd  : writes_dest_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q   <= 1'b0;
      opcode_q      <= '0;
      dest_q        <= '0;
      src1_q        <= '0;
      src2_q        <= '0;
      imm_q         <= '0;
      writes_dest_q <= 1'b0;
      busy_q        <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      opcode_q      <= opcode_d;
      dest_q        <= dest_d;
      src1_q        <= src1_d;
      src2_q        <= src2_d;
      imm_q         <= imm_d;
      writes_dest_q <= writes_dest_d;
      busy_q        <= busy_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign opcode       = opcode_q;
  assign reg_dest     = dest_q;
  assign reg_source_1 = src1_q;
  assign reg_source_2 = src2_q;
  assign immediate    = imm_q;
  assign writes_dest  = writes_dest_q;
  assign busy_mask    = busy_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors with hand-computed expectations for decode_stage.
module tb_decode_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b1;
  logic [32:0] instruction = '0;
  logic [4:0]  opcode;
  logic [3:0]  reg_dest, reg_source_1, reg_source_2, wb_reg = '0;
  logic [31:0] immediate;
  logic        writes_dest, wb_valid = 1'b0, hazard_stall;
  logic [15:0] busy_mask;
  int          n_checks = 0, n_pass = 0;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .opcode(opcode), .reg_dest(reg_dest),
    .reg_source_1(reg_source_1), .reg_source_2(reg_source_2),
    .immediate(immediate), .writes_dest(writes_dest), .wb_valid(wb_valid),
    .wb_reg(wb_reg), .busy_mask(busy_mask), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // advance one rising edge and land on the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [32:0] w, input logic wv, input logic [3:0] wr);
    in_valid = v;
    instruction = w;
    wb_valid = wv;
    wb_reg = wr;
  endtask

  initial begin
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy_mask, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_imm", immediate, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // field decode
    drive(1, 33'h011000010, 0, 0);
    #1 chk("dec1_in_ready", in_ready, 1);
    step();
    chk("dec1_valid", out_valid, 1);
    chk("dec1_opcode", opcode, 1);
    chk("dec1_dest", reg_dest, 1);
    chk("dec1_imm", immediate, 32'h00000010);
    chk("dec1_wd", writes_dest, 1);
    chk("dec1_busy", busy_mask, 16'h0002);
    drive(1, 33'h0E130FFFD, 1, 1);
    #1 chk("dec2_bypass_ready", in_ready, 1);
    step();
    chk("dec2_opcode", opcode, 14);
    chk("dec2_dest", reg_dest, 1);
    chk("dec2_src1", reg_source_1, 3);
    chk("dec2_src2", reg_source_2, 0);
    chk("dec2_imm", immediate, 32'hFFFFFFFD);
    chk("dec2_busy_set_wins", busy_mask, 16'h0002);
    drive(0, '0, 1, 1);
    step();
    chk("clr1_busy", busy_mask, 0);
    chk("clr1_valid", out_valid, 0);
    // RAW stall
    drive(1, 33'h011000010, 0, 0);
    step();
    chk("raw_busy1", busy_mask, 16'h0002);
    drive(1, 33'h052210000, 0, 0);
    #1 chk("raw_in_ready", in_ready, 0);
    chk("raw_stall", hazard_stall, 1);
    step();
    chk("raw_not_accepted", out_valid, 0);
    chk("raw_still_stall", hazard_stall, 1);
    wb_valid = 1'b1;
    wb_reg = 4'd1;
    #1 chk("raw_wb_ready", in_ready, 1);
    chk("raw_wb_nostall", hazard_stall, 0);
    step();
    chk("raw_opcode", opcode, 5);
    chk("raw_busy2", busy_mask, 16'h0004);
    drive(0, '0, 1, 2);
    step();
    chk("clr2_busy", busy_mask, 0);
    // back-pressure
    drive(1, 33'h02300000A, 0, 0);
    step();
    chk("bp_busy", busy_mask, 16'h0008);
    out_ready = 1'b0;
    drive(1, 33'h000000000, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", in_ready, 0);
      chk("bp_stall_not_hazard", hazard_stall, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_opcode", opcode, 2);
      chk("bp_dest", reg_dest, 3);
      chk("bp_imm", immediate, 32'h0000000A);
      step();
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", in_ready, 1);
    step();
    // NOP and register-0 destination
    chk("nop_valid", out_valid, 1);
    chk("nop_opcode", opcode, 0);
    chk("nop_wd", writes_dest, 0);
    chk("nop_busy", busy_mask, 16'h0008);
    drive(1, 33'h030200030, 0, 0);
    step();
    chk("r0_valid", out_valid, 1);
    chk("r0_opcode", opcode, 3);
    chk("r0_src1", reg_source_1, 2);
    chk("r0_wd", writes_dest, 0);
    chk("r0_busy", busy_mask, 16'h0008);
    drive(0, '0, 1, 3);
    step();
    chk("clr3_busy", busy_mask, 0);
    chk("clr3_valid", out_valid, 0);
    // flush of a held instruction
    drive(1, 33'h022000000, 0, 0);
    step();
    chk("fl_busy", busy_mask, 16'h0004);
    out_ready = 1'b0;
    flush = 1'b1;
    drive(1, 33'h02300000A, 0, 0);
    #1 chk("fl_in_ready", in_ready, 0);
    chk("fl_stall", hazard_stall, 0);
    step();
    chk("fl_valid", out_valid, 0);
    chk("fl_busy_cleared", busy_mask, 0);
    flush = 1'b0;
    out_ready = 1'b1;
    // asynchronous reset mid-stream
    drive(1, 33'h011000010, 0, 0);
    step();
    drive(1, 33'h022000000, 0, 0);
    step();
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_busy", busy_mask, 16'h0006);
    drive(0, '0, 0, 0);
    #2 rst_n = 1'b0;
    #1 chk("arst_valid", out_valid, 0);
    chk("arst_busy", busy_mask, 0);
    chk("arst_opcode", opcode, 0);
    chk("arst_dest", reg_dest, 0);
    chk("arst_imm", immediate, 0);
    chk("arst_wd", writes_dest, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", out_valid, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
